// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit.
//   Multiply: shift-add, N iterations, full 2N-bit product in {hi,lo}.
//   Divide:   restoring shift-subtract, N iterations, lo=quotient, hi=remainder.
//   A zero divisor is caught at the start edge and finishes in one cycle.
// Optional macro MDU_SIGNED_EN: ops 0 (MULT) and 2 (DIV) are two's-complement
//   signed; without it they behave as MULTU/DIVU.
// Ports:
//   clock, reset (async, active low)
//   start, op[1:0] (0 MULT, 1 MULTU, 2 DIV, 3 DIVU), inA, inB  - request
//   busy, done (1-cycle pulse), div_by_zero, hi, lo             - status/result
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           is_div_q;
  logic [N-1:0]   acc_q;   // partial product high half / partial remainder
  logic [N-1:0]   sh_q;    // multiplier shifting out / dividend->quotient
  logic [N-1:0]   opb_q;   // multiplicand / divisor (magnitude)
  logic           busy_q, done_q, dbz_q;
  logic [N-1:0]   hi_q, lo_q;

  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum, div_sh, div_diff;
  logic [N-1:0]   acc_d, sh_d, res_hi, res_lo;

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg;
  logic negq_q;            // product / quotient must be negated
  logic negr_q;            // remainder must be negated (follows dividend)
`else
  logic unused_op0;
  assign unused_op0 = op[0];
`endif

  // Operand magnitudes presented at the start edge.
  always_comb begin
    a_mag = inA;
    b_mag = inB;
`ifdef MDU_SIGNED_EN
    a_neg = 1'b0;
    b_neg = 1'b0;
    if (!op[0]) begin
      a_neg = inA[N-1];
      b_neg = inB[N-1];
      if (a_neg) a_mag = -inA;
      if (b_neg) b_mag = -inB;
    end
`endif
  end

  // One iteration step plus the sign-corrected result of that step.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q, sh_q[N-1]};
    div_diff = div_sh - {1'b0, opb_q};
    if (is_div_q) begin
      // div_diff[N] set means the trial subtraction borrowed: restore.
      if (!div_diff[N]) begin
        acc_d = div_diff[N-1:0];
        sh_d  = {sh_q[N-2:0], 1'b1};
      end else begin
        acc_d = div_sh[N-1:0];
        sh_d  = {sh_q[N-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[N:1];
      sh_d  = {mul_sum[0], sh_q[N-1:1]};
    end
    res_hi = acc_d;
    res_lo = sh_d;
`ifdef MDU_SIGNED_EN
    if (is_div_q) begin
      if (negq_q) res_lo = -sh_d;
      if (negr_q) res_hi = -acc_d;
    end else if (negq_q) begin
      {res_hi, res_lo} = -{acc_d, sh_d};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opb_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_SIGNED_EN
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dbz_q <= 1'b0;
          if (op[1] && inB == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            lo_q    <= '1;
            hi_q    <= inA;
          end else begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(N);
            is_div_q <= op[1];
            acc_q    <= '0;
            sh_q     <= op[1] ? a_mag : b_mag;
            opb_q    <= op[1] ? b_mag : a_mag;
`ifdef MDU_SIGNED_EN
            negq_q   <= a_neg ^ b_neg;
            negr_q   <= a_neg;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: N, default 32, operand width in bits; legal values 8..64, even.
REQ-002 Port: clock  input  1  system clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on posedge clock.
REQ-005 Port: op  input  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 Port: inA  input  N  multiplicand or dividend.
REQ-007 Port: inB  input  N  multiplier or divisor.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when hi and lo hold a new result.
REQ-010 Port: div_by_zero  output  1  high with done when the divisor was zero; held until the next accepted start.
REQ-011 Port: hi  output  N  product upper half, or division remainder.
REQ-012 Port: lo  output  N  product lower half, or division quotient.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, held in a registered state variable.
REQ-014 In IDLE with start=1: latch op, inA and inB; clear div_by_zero; load the iteration counter with N; go to RUN; busy=1 from this edge.
REQ-015 A start pulse in RUN or DONE SHALL be ignored, with no effect on state, operands or outputs.
REQ-016 RUN SHALL execute one radix-2 iteration per posedge: shift-add for multiply, restoring shift-subtract for divide; the counter decrements each posedge.
REQ-017 When the counter reaches 0, the unit SHALL write hi and lo, go to DONE and drop busy at that same edge.
REQ-018 done SHALL be high only in DONE, for exactly one cycle; DONE returns to IDLE on the next posedge unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following the Nth posedge after the edge that sampled start.
REQ-020 Multiply: {hi,lo} SHALL equal the full 2N-bit product; it never overflows.
REQ-021 Divide: lo SHALL equal the quotient truncated toward zero; hi SHALL equal the remainder, with the sign of the dividend.
REQ-022 Divisor zero, detected in IDLE at the start edge: go directly to DONE (done one cycle after start); lo = all ones; hi = inA; div_by_zero=1.
REQ-023 Signed DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no error flag.
REQ-024 Signed operations SHALL iterate on magnitudes and apply sign correction combinationally on the final write, with no extra cycle.
REQ-025 hi and lo SHALL hold their value between results; they change only on a result write or on reset.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clock, force: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation, with no partial result written; after release, the unit accepts start on the first posedge.

Configuration
REQ-028 Macro MDU_SIGNED_EN: when defined, MULT and DIV perform two's-complement signed arithmetic as specified above.
REQ-029 Without MDU_SIGNED_EN, op 0 SHALL behave as op 1 and op 2 as op 3 (unsigned), sign-correction logic is not built, and latency is unchanged.

Verification (N=32, MDU_SIGNED_EN defined unless stated)
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 32 posedges after the start edge; busy high throughout.
REQ-031 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without MDU_SIGNED_EN -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU 100 / 0 -> done the cycle after start, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000064; the next accepted start clears div_by_zero.
REQ-034 Start DIVU 1000/7; pulse start with other operands at RUN cycle 5 -> ignored, result lo=142, hi=6; then assert reset at RUN cycle 10 of a new op -> busy, done, hi and lo become 0 before the next clock edge.
